// File: rtl/timer_axil_slave_if.sv
// timer_axil_slave_if: AXI4-Lite register-port bundle
// between the bus master and the timer responder.
interface timer_axil_slave_if #(
  parameter int ADDR_W = 4,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   awaddr;
  logic [2:0]          awprot;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;
  logic [ADDR_W-1:0]   araddr;
  logic [2:0]          arprot;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;

  modport master (
    output awaddr, awprot, awvalid,
    input  awready,
    output wdata, wstrb, wvalid,
    input  wready,
    input  bresp, bvalid,
    output bready,
    output araddr, arprot, arvalid,
    input  arready,
    input  rdata, rresp, rvalid,
    output rready
  );

  modport slave (
    input  awaddr, awprot, awvalid,
    output awready,
    input  wdata, wstrb, wvalid,
    output wready,
    output bresp, bvalid,
    input  bready,
    input  araddr, arprot, arvalid,
    output arready,
    output rdata, rresp, rvalid,
    input  rready
  );
endinterface

// File: rtl/timer_axil_slave.sv
// timer_axil_slave: AXI4-Lite register port for a prescaled
// 32-bit down-counter timer with a level interrupt on expiry.
module timer_axil_slave #(
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 4,
  parameter int PRESCALE = 1
) (
  input  logic              s00_axi_aclk,
  input  logic              s00_axi_aresetn,
  timer_axil_slave_if.slave s00_axi,
  output logic              irq
);
  localparam int DW = C_S_AXI_DATA_WIDTH;
  localparam int AW = C_S_AXI_ADDR_WIDTH;
  localparam logic [15:0] PMAX = 16'(PRESCALE - 1);

  logic          rdy;
  logic          aw_held;
  logic          w_held;
  logic [1:0]    aw_sel;
  logic [DW-1:0] wdata_q;
  logic [3:0]    wstrb_q;
  logic          bvalid;
  logic          rvalid;
  logic [DW-1:0] rdata_q;

  logic          en;
  logic          reload;
  logic          ie;
  logic          expired;
  logic [DW-1:0] load;
  logic [DW-1:0] count;
  logic [15:0]   presc;

  logic          aw_hs;
  logic          w_hs;
  logic          ar_hs;
  logic          commit;
  logic          tick;
  logic          wr_ctrl;
  logic          wr_load;
  logic          wr_stat;
  logic [1:0]    ar_sel;
  logic [DW-1:0] rd_mux;

  logic          en_n;
  logic          reload_n;
  logic          ie_n;
  logic          expired_n;
  logic [DW-1:0] load_n;
  logic [DW-1:0] count_n;
  logic [15:0]   presc_n;

  logic          unused_ok;

  assign unused_ok = ^{s00_axi.awprot,
                       s00_axi.arprot,
                       s00_axi.awaddr[1:0],
                       s00_axi.araddr[1:0]};

  assign s00_axi.awready = rdy & ~aw_held & ~bvalid;
  assign s00_axi.wready  = rdy & ~w_held & ~bvalid;
  assign s00_axi.arready = rdy & ~rvalid;
  assign s00_axi.bvalid  = bvalid;
  assign s00_axi.bresp   = 2'b00;
  assign s00_axi.rvalid  = rvalid;
  assign s00_axi.rdata   = rdata_q;
  assign s00_axi.rresp   = 2'b00;

  assign aw_hs = s00_axi.awvalid & s00_axi.awready;
  assign w_hs  = s00_axi.wvalid & s00_axi.wready;
  assign ar_hs = s00_axi.arvalid & s00_axi.arready;

  assign commit  = aw_held & w_held;
  assign wr_ctrl = commit & (aw_sel == 2'd0);
  assign wr_load = commit & (aw_sel == 2'd1);
  assign wr_stat = commit & (aw_sel == 2'd3);
  assign tick    = en & (presc == PMAX);
  assign ar_sel  = s00_axi.araddr[AW-1 -: 2];

  always_comb begin
    rd_mux = '0;
    unique case (1'b1)
      ar_sel == 2'd0: rd_mux[2:0] = {ie, reload, en};
      ar_sel == 2'd1: rd_mux = load;
      ar_sel == 2'd2: rd_mux = count;
      ar_sel == 2'd3: rd_mux[0] = expired;
      default:        rd_mux = '0;
    endcase
  end

  // Later assignments take priority: tick set beats W1C,
  // and a CTRL write beats the hardware EN clear.
  always_comb begin
    en_n      = en;
    reload_n  = reload;
    ie_n      = ie;
    expired_n = expired;
    load_n    = load;
    count_n   = count;
    presc_n   = tick ? '0 : presc + 16'd1;

    if (wr_stat & wstrb_q[0] & wdata_q[0])
      expired_n = 1'b0;

    if (tick) begin
      if (count != '0) begin
        count_n = count - DW'(1);
      end else begin
        expired_n = 1'b1;
        if (reload) count_n = load;
        else        en_n = 1'b0;
      end
    end

    for (int b = 0; b < 4; b++) begin
      if (wr_load & wstrb_q[b])
        load_n[8*b +: 8] = wdata_q[8*b +: 8];
    end

    if (wr_ctrl & wstrb_q[0]) begin
      en_n     = wdata_q[0];
      reload_n = wdata_q[1];
      ie_n     = wdata_q[2];
      if (wdata_q[0] & ~en) begin
        count_n = load;
        presc_n = '0;
      end
    end

    if (!en_n) presc_n = '0;
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      rdy     <= 1'b0;
      aw_held <= 1'b0;
      w_held  <= 1'b0;
      aw_sel  <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      bvalid  <= 1'b0;
      rvalid  <= 1'b0;
      rdata_q <= '0;
    end else begin
      rdy <= 1'b1;
      if (commit) begin
        aw_held <= 1'b0;
      end else if (aw_hs) begin
        aw_held <= 1'b1;
        aw_sel  <= s00_axi.awaddr[AW-1 -: 2];
      end
      if (commit) begin
        w_held <= 1'b0;
      end else if (w_hs) begin
        w_held  <= 1'b1;
        wdata_q <= s00_axi.wdata;
        wstrb_q <= s00_axi.wstrb;
      end
      if (commit)
        bvalid <= 1'b1;
      else if (bvalid & s00_axi.bready)
        bvalid <= 1'b0;
      if (ar_hs) begin
        rvalid  <= 1'b1;
        rdata_q <= rd_mux;
      end else if (rvalid & s00_axi.rready) begin
        rvalid <= 1'b0;
      end
    end
  end

  always_ff @(posedge s00_axi_aclk or negedge s00_axi_aresetn) begin
    if (!s00_axi_aresetn) begin
      en      <= 1'b0;
      reload  <= 1'b0;
      ie      <= 1'b0;
      expired <= 1'b0;
      load    <= '0;
      count   <= '0;
      presc   <= '0;
      irq     <= 1'b0;
    end else begin
      en      <= en_n;
      reload  <= reload_n;
      ie      <= ie_n;
      expired <= expired_n;
      load    <= load_n;
      count   <= count_n;
      presc   <= presc_n;
      irq     <= expired_n & ie_n;
    end
  end
endmodule

// File: tb/tb_timer_axil_slave.sv
// tb_timer_axil_slave: directed bench for the timer
// register port, counter, interrupt and reset behaviour.
module tb_timer_axil_slave;
  logic clk;
  logic rst_n;
  logic irq;
  int   cyc;
  int   checks;
  int   failures;
  int   commit_cyc;
  int   ar_cyc;
  int   e;
  int   s;
  int   h;
  logic [31:0] r;
  logic [31:0] exp_cnt;
  bit   irq_log [0:4095];

  timer_axil_slave_if #(.ADDR_W(4), .DATA_W(32)) bus ();

  timer_axil_slave #(
    .C_S_AXI_DATA_WIDTH(32),
    .C_S_AXI_ADDR_WIDTH(4),
    .PRESCALE(1)
  ) dut (
    .s00_axi_aclk(clk),
    .s00_axi_aresetn(rst_n),
    .s00_axi(bus),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (cyc < 4096) irq_log[cyc] = irq;
  end

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick_to(input int t);
    int n;
    n = 0;
    while (cyc < t && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    check("tick_to", 32'(cyc), 32'(t));
  endtask

  task automatic axi_write(input logic [3:0] a,
                           input logic [31:0] d,
                           input logic [3:0] st = 4'hF);
    int n;
    bit aw_done, w_done, ahs, whs;
    aw_done = 0;
    w_done  = 0;
    n = 0;
    bus.awaddr  = a;
    bus.awvalid = 1'b1;
    bus.wdata   = d;
    bus.wstrb   = st;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b1;
    while (!(aw_done && w_done) && n < 20) begin
      ahs = bus.awvalid & bus.awready;
      whs = bus.wvalid & bus.wready;
      @(posedge clk); #1;
      if (ahs) begin aw_done = 1; bus.awvalid = 1'b0; end
      if (whs) begin w_done = 1; bus.wvalid = 1'b0; end
      n++;
    end
    while (!bus.bvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("wr_done", 32'(bus.bvalid), 32'd1);
    check("bresp", 32'(bus.bresp), 32'd0);
    commit_cyc = cyc;
    @(posedge clk); #1;
    bus.bready  = 1'b0;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
  endtask

  task automatic axi_read(input logic [3:0] a,
                          output logic [31:0] d);
    int n;
    bit hs;
    hs = 0;
    n = 0;
    bus.araddr  = a;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b1;
    while (!hs && n < 20) begin
      hs = bus.arready;
      @(posedge clk); #1;
      n++;
      if (hs) begin
        bus.arvalid = 1'b0;
        ar_cyc = cyc;
      end
    end
    while (!bus.rvalid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("rd_done", 32'(bus.rvalid), 32'd1);
    check("rresp", 32'(bus.rresp), 32'd0);
    d = bus.rdata;
    @(posedge clk); #1;
    bus.rready  = 1'b0;
    bus.arvalid = 1'b0;
  endtask

  // One channel at offset 0, the other at offset 3,
  // then BREADY held low for 4 cycles.
  task automatic stagger(input bit aw_first,
                         input logic [31:0] d);
    bus.bready = 1'b0;
    bus.awaddr = 4'h4;
    bus.wdata  = d;
    bus.wstrb  = 4'hF;
    if (aw_first) bus.awvalid = 1'b1;
    else          bus.wvalid  = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("stg_held_rdy",
          32'(aw_first ? bus.awready : bus.wready), 32'd0);
    check("stg_free_rdy",
          32'(aw_first ? bus.wready : bus.awready), 32'd1);
    check("stg_b_none", 32'(bus.bvalid), 32'd0);
    if (aw_first) bus.wvalid  = 1'b1;
    else          bus.awvalid = 1'b1;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    check("stg_b_early", 32'(bus.bvalid), 32'd0);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      check("stg_b_hold", 32'(bus.bvalid), 32'd1);
      check("stg_aw_stall", 32'(bus.awready), 32'd0);
      check("stg_w_stall", 32'(bus.wready), 32'd0);
      @(posedge clk); #1;
    end
    bus.bready = 1'b1;
    @(posedge clk); #1;
    check("stg_b_clr", 32'(bus.bvalid), 32'd0);
    @(posedge clk); #1;
    check("stg_b_once", 32'(bus.bvalid), 32'd0);
    bus.bready = 1'b0;
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst_n    = 1'b0;
    bus.awaddr  = '0;
    bus.awprot  = '0;
    bus.awvalid = 1'b0;
    bus.wdata   = '0;
    bus.wstrb   = '0;
    bus.wvalid  = 1'b0;
    bus.bready  = 1'b0;
    bus.araddr  = '0;
    bus.arprot  = '0;
    bus.arvalid = 1'b0;
    bus.rready  = 1'b0;

    // reset defaults
    repeat (3) @(posedge clk);
    #1;
    check("rst_bvalid", 32'(bus.bvalid), 32'd0);
    check("rst_rvalid", 32'(bus.rvalid), 32'd0);
    check("rst_awready", 32'(bus.awready), 32'd0);
    check("rst_arready", 32'(bus.arready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    #2 rst_n = 1'b1;
    #1;
    check("rel_awready", 32'(bus.awready), 32'd0);
    @(posedge clk); #1;
    check("rel_awready1", 32'(bus.awready), 32'd1);
    check("rel_wready1", 32'(bus.wready), 32'd1);
    check("rel_arready1", 32'(bus.arready), 32'd1);
    axi_read(4'h0, r); check("def_ctrl", r, 32'h0);
    axi_read(4'h4, r); check("def_load", r, 32'h0);
    axi_read(4'h8, r); check("def_count", r, 32'h0);
    axi_read(4'hC, r); check("def_stat", r, 32'h0);
    check("def_irq", 32'(irq), 32'd0);

    // one-shot: COUNT 5 at e, expires on edge e+6
    axi_write(4'h4, 32'd5);
    axi_write(4'h0, 32'h5);
    e = commit_cyc;
    axi_read(4'h8, r); check("os_cnt_a", r, 32'd4);
    axi_read(4'h8, r); check("os_cnt_b", r, 32'd2);
    axi_read(4'h8, r); check("os_cnt_c", r, 32'd0);
    check("os_ar_cyc", 32'(ar_cyc - e), 32'd6);
    check("os_irq_pre", 32'(irq_log[e+5]), 32'd0);
    check("os_irq_at", 32'(irq_log[e+6]), 32'd1);
    axi_read(4'hC, r); check("os_stat", r, 32'h1);
    axi_read(4'h0, r); check("os_ctrl", r, 32'h4);
    axi_read(4'h8, r); check("os_cnt_hold", r, 32'd0);
    check("os_irq_hold", 32'(irq), 32'd1);
    axi_write(4'hC, 32'h1);
    check("os_w1c_irq", 32'(irq_log[commit_cyc]), 32'd0);
    axi_read(4'hC, r); check("os_w1c_stat", r, 32'h0);

    // auto-reload: expiries at e+3, e+6, e+9, e+12
    axi_write(4'h4, 32'd2);
    axi_write(4'h0, 32'h7);
    e = commit_cyc;
    tick_to(e + 4);
    check("ar_irq_e2", 32'(irq_log[e+2]), 32'd0);
    check("ar_irq_e3", 32'(irq_log[e+3]), 32'd1);
    tick_to(e + 5);
    axi_write(4'hC, 32'h1);
    check("ar_w1c_cyc", 32'(commit_cyc - e), 32'd7);
    tick_to(e + 10);
    check("ar_irq_e6", 32'(irq_log[e+6]), 32'd1);
    check("ar_irq_e7", 32'(irq_log[e+7]), 32'd0);
    check("ar_irq_e8", 32'(irq_log[e+8]), 32'd0);
    check("ar_irq_e9", 32'(irq_log[e+9]), 32'd1);
    axi_write(4'hC, 32'h1);
    check("ar_w1c2_cyc", 32'(commit_cyc - e), 32'd12);
    tick_to(e + 14);
    check("ar_setwin_12", 32'(irq_log[e+12]), 32'd1);
    check("ar_setwin_13", 32'(irq_log[e+13]), 32'd1);
    axi_write(4'h0, 32'h0);
    axi_write(4'hC, 32'h1);
    axi_read(4'hC, r); check("ar_stop_stat", r, 32'h0);
    check("ar_stop_irq", 32'(irq), 32'd0);

    // staggered write channels
    stagger(1'b1, 32'h12345678);
    axi_read(4'h4, r); check("stg_aw_first", r, 32'h12345678);
    stagger(1'b0, 32'hCAFEF00D);
    axi_read(4'h4, r); check("stg_w_first", r, 32'hCAFEF00D);

    // read back-pressure on a live COUNT
    axi_write(4'h4, 32'd100);
    axi_write(4'h0, 32'h1);
    e = commit_cyc;
    bus.araddr  = 4'h8;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    h = cyc;
    exp_cnt = 32'(100 - (h - 1 - e));
    check("bp_rvalid", 32'(bus.rvalid), 32'd1);
    for (int i = 0; i < 5; i++) begin
      check("bp_rdata", bus.rdata, exp_cnt);
      check("bp_arready", 32'(bus.arready), 32'd0);
      @(posedge clk); #1;
    end
    bus.rready = 1'b1;
    @(posedge clk); #1;
    check("bp_rclr", 32'(bus.rvalid), 32'd0);
    bus.rready = 1'b0;
    axi_write(4'h0, 32'h0);
    s = commit_cyc;
    exp_cnt = 32'(100 - (s - e));
    axi_write(4'h8, 32'h0000FFFF);
    axi_read(4'h8, r); check("ro_count", r, exp_cnt);
    axi_read(4'h0, r); check("ro_ctrl", r, 32'h0);

    // byte strobes
    axi_write(4'h4, 32'h0);
    axi_write(4'h4, 32'hAABBCCDD, 4'h1);
    axi_read(4'h4, r); check("strb_b0", r, 32'h000000DD);
    axi_write(4'h4, 32'h11223344, 4'h6);
    axi_read(4'h4, r); check("strb_b12", r, 32'h002233DD);
    axi_write(4'h0, 32'h7, 4'h0);
    axi_read(4'h0, r); check("strb_ctrl0", r, 32'h0);

    // mid-count asynchronous reset
    axi_write(4'h4, 32'h0);
    axi_write(4'h0, 32'h7);
    tick_to(cyc + 2);
    check("mr_irq_on", 32'(irq), 32'd1);
    bus.araddr  = 4'h8;
    bus.arvalid = 1'b1;
    bus.rready  = 1'b0;
    @(posedge clk); #1;
    bus.arvalid = 1'b0;
    bus.awaddr  = 4'h4;
    bus.wdata   = 32'h55;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    bus.bready  = 1'b0;
    @(posedge clk); #1;
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    @(posedge clk); #1;
    check("mr_bvalid_on", 32'(bus.bvalid), 32'd1);
    check("mr_rvalid_on", 32'(bus.rvalid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("mr_bvalid", 32'(bus.bvalid), 32'd0);
    check("mr_rvalid", 32'(bus.rvalid), 32'd0);
    check("mr_irq", 32'(irq), 32'd0);
    check("mr_awready", 32'(bus.awready), 32'd0);
    check("mr_arready", 32'(bus.arready), 32'd0);
    @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    check("mr_rel_rdy", 32'(bus.awready), 32'd1);
    axi_read(4'h0, r); check("mr_ctrl", r, 32'h0);
    axi_read(4'h4, r); check("mr_load", r, 32'h0);
    axi_read(4'h8, r); check("mr_count", r, 32'h0);
    axi_read(4'hC, r); check("mr_stat", r, 32'h0);
    tick_to(cyc + 5);
    check("mr_irq_idle", 32'(irq), 32'd0);
    axi_read(4'h8, r); check("mr_count_idle", r, 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
